// File: rtl/spi_globals_pkg.sv
// Shared types and defaults for the SPI slave receive path.
package spi_globals_pkg;

    typedef enum {MSB_FIRST, LSB_FIRST} shift_direction_e;

    typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} rx_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_rx_sync_fifo.sv
// First-word fall-through receive FIFO. A push into a full FIFO is accepted only
// alongside a pop; otherwise it is dropped and reported on `drop`.
module spi_rx_sync_fifo
    import spi_globals_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (count_q == LW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    // Hold the data output at zero while empty so reset and drained states read 0.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        drop     = push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_slave_rx_deserializer.sv
// SPI slave receive front-end: synchronizers, sclk edge detect, framing FSM and shift
// register feeding a receive FIFO. Define SPI_RX_OVF_CNT_EN to add the ovf_count output.
module spi_slave_rx_deserializer
    import spi_globals_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          lsb_first,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi0,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          frame_err
`ifdef SPI_RX_OVF_CNT_EN
    ,
    output logic [7:0]                    ovf_count
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0]  sr_q, sr_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;
    logic                   push_q, push_d;
    logic                   frame_err_q, frame_err_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    shift_direction_e       dir_q, dir_d;
    logic                   overflow_q, overflow_d;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise, sample;
    logic [DATA_WIDTH-1:0]  sr_shift;
    logic                   fifo_full, fifo_empty, fifo_drop, pop;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign sample    = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    assign sr_shift  = (dir_q == LSB_FIRST) ? {mosi_s, sr_q[DATA_WIDTH-1:1]}
                                            : {sr_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi0};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        word_d      = word_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        dir_d       = dir_q;
        case (state_q)
            RX_IDLE: begin
                if (cs_fall) begin
                    state_d  = RX_SHIFT;
                    bitcnt_d = '0;
                    sr_d     = '0;
                    cpol_d   = cpol;
                    cpha_d   = cpha;
                    dir_d    = lsb_first ? LSB_FIRST : MSB_FIRST;
                end
            end
            RX_SHIFT: begin
                if (sample) begin
                    sr_d = sr_shift;
                    if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
                        push_d   = 1'b1;
                        word_d   = sr_shift;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
                end
                // A word completing on the same cycle as cs rising is a clean end of frame.
                if (cs_rise) begin
                    frame_err_d = (bitcnt_d != '0);
                    state_d     = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Sync chains reset low so a cs held low through reset does not look like a new frame.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= RX_IDLE;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            word_q      <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            dir_q       <= MSB_FIRST;
            overflow_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            word_q      <= word_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            dir_q       <= dir_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SPI_RX_OVF_CNT_EN
    logic [7:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (fifo_drop) begin
            ovf_count_d = (ovf_count_q == 8'hFF) ? ovf_count_q : ovf_count_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_count_d = '0;
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

    assign pop       = rx_valid && rx_ready;
    assign rx_valid  = !fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    spi_rx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk   (pclk),
        .areset (areset),
        .push   (push_q),
        .wdata  (word_q),
        .pop    (pop),
        .rdata  (rx_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level),
        .drop   (fifo_drop)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_spi_slave_rx_deserializer.sv
// Scoreboard bench: an SPI master drives random and directed frames, expected words are
// queued as sent and a monitor pops/compares on every rx_valid&&rx_ready handshake.
module tb_spi_slave_rx_deserializer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 2;
    localparam int H = 4;

    logic pclk = 1'b0;
    logic areset = 1'b0;
    logic cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic sclk = 1'b0, cs = 1'b1, mosi0 = 1'b0;
    logic rx_ready = 1'b0, ovf_clr = 1'b0;
    logic [W-1:0] rx_data;
    logic rx_valid, overflow, frame_err;
    logic [$clog2(D):0] fifo_level;
`ifdef SPI_RX_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    spi_slave_rx_deserializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
        .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .sclk(sclk), .cs(cs), .mosi0(mosi0), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_level(fifo_level), .overflow(overflow),
        .ovf_clr(ovf_clr), .frame_err(frame_err)
`ifdef SPI_RX_OVF_CNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    always #5 pclk = ~pclk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int exp_ferr = 0, seen_ferr = 0;
    int rise_cyc = 0, sample_cyc = 0;
    bit hold_ready = 1'b1;
    bit m_cpol, m_cpha, m_lsb;
    logic [W-1:0] exp_q[$];

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(negedge pclk);
        rx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Monitor: one sample per cycle, after rx_ready for the coming edge has settled.
    initial begin
        logic prev_v;
        logic [W-1:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge pclk);
            #1;
            if (!areset) begin
                prev_v = 1'b0;
            end else begin
                if (rx_valid && !prev_v) rise_cyc = cyc;
                prev_v = rx_valid;
                if (frame_err) seen_ferr++;
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word got %0h expected none", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_word", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic start_frame(input bit pol, input bit pha, input bit lsb);
        m_cpol = pol; m_cpha = pha; m_lsb = lsb;
        cpol = pol; cpha = pha; lsb_first = lsb;
        sclk = pol; cs = 1'b1;
        wait_cyc(6);
        cs = 1'b0;
        wait_cyc(H);
    endtask

    task automatic end_frame();
        wait_cyc(H);
        cs = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send_bit(input bit b);
        if (!m_cpha) begin
            mosi0 = b;
            wait_cyc(H);
            sclk = ~m_cpol;
            sample_cyc = cyc;
            wait_cyc(H);
            sclk = m_cpol;
        end else begin
            sclk = ~m_cpol;
            mosi0 = b;
            wait_cyc(H);
            sclk = m_cpol;
            sample_cyc = cyc;
            wait_cyc(H);
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit expect_kept);
        if (expect_kept) exp_q.push_back(w);
        for (int i = 0; i < W; i++) send_bit(m_lsb ? w[i] : w[W-1-i]);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            wait_cyc(1);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
        end
        wait_cyc(4);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_level", fifo_level, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_frame_err", frame_err, 0);
        areset = 1'b1;
        wait_cyc(4);

        // Mode 0 MSB-first with latency measurement on an empty FIFO
        start_frame(0, 0, 0);
        send_word(8'hA5, 1);
        end_frame();
        chk("latency", rise_cyc - sample_cyc, S + 2);
        hold_ready = 1'b0;
        drain();

        // Mode 3 LSB-first, two words in one frame
        start_frame(1, 1, 1);
        send_word(8'h3C, 1);
        send_word(8'hC3, 1);
        end_frame();
        drain();
        chk("ferr_after_mode3", seen_ferr, exp_ferr);

        // Overflow: consumer stalled, five words into four entries
        hold_ready = 1'b1;
        wait_cyc(2);
        start_frame(0, 0, 0);
        send_word(8'h11, 1);
        send_word(8'h22, 1);
        send_word(8'h33, 1);
        send_word(8'h44, 1);
        send_word(8'h55, 0);
        end_frame();
        chk("ovf_level", fifo_level, D);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", rx_data, 8'h11);
`ifdef SPI_RX_OVF_CNT_EN
        chk("ovf_count", ovf_count, 1);
`endif
        ovf_clr = 1'b1;
        wait_cyc(1);
        ovf_clr = 1'b0;
        wait_cyc(1);
        chk("ovf_cleared", overflow, 0);
`ifdef SPI_RX_OVF_CNT_EN
        chk("ovf_count_cleared", ovf_count, 0);
`endif
        hold_ready = 1'b0;
        drain();

        // Mode 1 partial frame then a clean word
        start_frame(0, 1, 0);
        send_partial(5);
        exp_ferr++;
        end_frame();
        start_frame(0, 1, 0);
        send_word(8'h81, 1);
        end_frame();
        drain();
        chk("ferr_partial", seen_ferr, exp_ferr);

        // Reset in the middle of a frame
        start_frame(0, 0, 0);
        send_partial(3);
        areset = 1'b0;
        wait_cyc(2);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_overflow", overflow, 0);
        cs = 1'b1;
        sclk = 1'b0;
        wait_cyc(3);
        areset = 1'b1;
        wait_cyc(4);
        start_frame(0, 0, 0);
        send_word(8'h5A, 1);
        end_frame();
        drain();
        chk("ferr_after_reset", seen_ferr, exp_ferr);

        // Mode pins change mid-frame; the mode latched at cs fall must be used
        start_frame(1, 0, 0);
        cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b1;
        send_word(8'hF0, 1);
        end_frame();
        drain();

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            int nw;
            start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) send_word(W'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin
                send_partial($urandom_range(1, W - 1));
                exp_ferr++;
            end
            end_frame();
        end
        drain();
        chk("ferr_total", seen_ferr, exp_ferr);
        chk("final_level", fifo_level, 0);
        chk("final_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
